ex_unit: RTL

EX_UNIT -- requirements
Module: ex_unit

---
 rtl/ex_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/ex_unit.sv
// ex_unit: execute stage with single-cycle logic/shift ops and a 32-step shift-add multiplier
module ex_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d, mcand_q, mcand_d, acc_nx;
  logic [31:0] mplr_q, mplr_d;
  logic [4:0]  mwd_q, mwd_d, wd_d;
  logic        mwreg_q, mwreg_d, wreg_d;
  logic [31:0] wdata_d, logic_res, shift_res, op_res;
  logic        is_mul;
  // single-cycle result decode and one shift-add step of the multiplier
  always_comb begin
    logic_res = aluop_i == 8'h25 ? reg1_i | reg2_i :
                aluop_i == 8'h24 ? reg1_i & reg2_i :
                aluop_i == 8'h26 ? reg1_i ^ reg2_i :
                aluop_i == 8'h27 ? ~(reg1_i | reg2_i) : 32'h0;
    shift_res = aluop_i == 8'h7C ? reg2_i << reg1_i[4:0] :
                aluop_i == 8'h02 ? reg2_i >> reg1_i[4:0] :
                aluop_i == 8'h03 ? $unsigned($signed(reg2_i) >>> reg1_i[4:0]) : 32'h0;
    op_res    = alusel_i == 3'b001 ? logic_res : alusel_i == 3'b010 ? shift_res : 32'h0;
    is_mul    = alusel_i == 3'b011 && aluop_i == 8'h18;
    acc_nx    = acc_q + (mplr_q[0] ? mcand_q : 64'h0);
    stallreq_o = state_q == BUSY;
  end
  // next state: flush wins, IDLE accepts an instruction, BUSY steps the multiplier
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    mwd_d   = mwd_q;
    mwreg_d = mwreg_q;
    wd_d    = wd_o;
    wreg_d  = wreg_o;
    wdata_d = wdata_o;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
      acc_d   = 64'h0;
      wd_d    = 5'd0;
      wreg_d  = 1'b0;
      wdata_d = 32'h0;
    end else if (state_q == IDLE) begin
      wd_d = wd_i;
      if (is_mul) begin
        state_d = BUSY;
        cnt_d   = 5'd0;
        acc_d   = 64'h0;
        mcand_d = {32'h0, reg1_i};
        mplr_d  = reg2_i;
        mwd_d   = wd_i;
        mwreg_d = wreg_i;
        wreg_d  = 1'b0;
        wdata_d = 32'h0;
      end else begin
        wreg_d  = wreg_i;
        wdata_d = op_res;
      end
    end else begin
      acc_d   = acc_nx;
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      cnt_d   = cnt_q + 5'd1;
      wreg_d  = 1'b0;
      if (cnt_q == 5'd31) begin
        state_d = IDLE;
        wdata_d = acc_nx[31:0];
        wd_d    = mwd_q;
        wreg_d  = mwreg_q;
      end
    end
  end
  // state and output registers, cleared asynchronously while rst is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      acc_q   <= 64'h0;
      mcand_q <= 64'h0;
      mplr_q  <= 32'h0;
      mwd_q   <= 5'd0;
      mwreg_q <= 1'b0;
      wd_o    <= 5'd0;
      wreg_o  <= 1'b0;
      wdata_o <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      mwd_q   <= mwd_d;
      mwreg_q <= mwreg_d;
      wd_o    <= wd_d;
      wreg_o  <= wreg_d;
      wdata_o <= wdata_d;
    end
  end
endmodule
